fnd_scan_ctrl: RTL
==================

# fnd_scan_ctrl

Sequential driver for the 4-digit common-anode FND on the calculator board. Accepts a binary result (e.g. the add/sub output widened to 14 bits), converts it to four BCD digits with a multi-cycle shift-add-3 converter, and time-multiplexes the digits onto the shared anode/segment lines. It generates the digit select and font internally and sits between the arithmetic datapath and the board pins.

## Interface
- `SCAN_DIV`, 100_000: clock cycles each digit is lit (1 kHz per digit at 100 MHz); minimum 2.
- `i_clk` in 1: system clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_value` in 14: binary value to display.
- `i_load` in 1: capture request; accepted only when `o_busy`=0.
- `i_en` in 1: display enable; 0 blanks all digits.
- `o_busy` in/out: out 1: conversion in progress.
- `o_digit` out 4: anode enables, active-low; bit0 = ones digit.
- `o_font` out 8: segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Capture: on an edge with `i_load`=1 and `o_busy`=0, the converter latches `i_value` saturated to 9999, clears its BCD accumulator and sets `o_busy`. An `i_load` while busy is ignored; no queueing.
- Conversion: 14 iterations, one per clock. Each iteration adds 3 to every BCD nibble ≥5, then shifts the combined {bcd, bin} register left by 1. On the 14th iteration the 16-bit BCD result is written to the display register and `o_busy` clears. The display register is unchanged until then, so the old value stays visible.
- Scan: the prescaler counts 0..SCAN_DIV-1. At the terminal count the digit index advances 0→1→2→3→0. The index selects the BCD nibble.
- Font, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. dp is always off (bit7=1).
- Leading-zero blanking: a digit above the most significant nonzero digit drives `o_digit`=1111 and `o_font`=FF for its slot. Digit 0 is never blanked, and internal zeros are shown.
- Enabled output: `o_digit` = ~(1<<idx).
- `i_en`=0: outputs 1111/FF. Prescaler and index keep running, and conversion is unaffected.

## Timing
- Reset values: `o_digit`=1111, `o_font`=FF, `o_busy`=0, display register=0000, idx=0, prescaler=0, converter idle.
- Reset mid-conversion aborts the conversion. The display returns to 0, and no partial result is committed.
- `o_digit` and `o_font` are registered from idx, the display register and `i_en`, with one cycle of latency.
  - First cycle after reset release: outputs 1110/C0.
- Load accept edge N: `o_busy` is high after edges N..N+13 and low after edge N+14. The display register is updated at edge N+14, and the outputs reflect it after edge N+15.
- A load accepted on the same edge `o_busy` falls is not possible, since `o_busy` is still 1 at that edge. The earliest next accept is edge N+15.
- Each index is held for exactly SCAN_DIV cycles. The prescaler wraps 0 to 0 across digit 3→0 without a gap.
- A scan tick coincident with a display-register update uses the new register on the following output cycle. No glitch holds longer than one cycle.

## Structure
- Package `fnd_pkg`:
  - Constants: `FND_DIGITS`=4, `MAX_VALUE`=9999, `FONT_BLANK`=8'hFF, `DIGIT_OFF`=4'b1111.
  - Ten font constants, and a function `bcd_to_font`, with out-of-range input mapping to `FONT_BLANK`.
- Sub-module `bin2bcd_seq`: the load/busy iterative converter with ports clk, reset, start, bin[13:0], busy, done, bcd[15:0].
- The top level holds the saturation, display register, prescaler, index, blanking logic and output registers.

## Test plan
Benches run with SCAN_DIV=4.
1. Reset held 3 cycles then released: outputs 1111/FF during reset. First post-reset output is 1110/C0. Digits 1–3 slots show 1111/FF.
2. Load 1234: `o_busy` high for exactly 14 cycles. Then each pair is held 4 cycles: 1110/99, 1101/B0, 1011/A4, 0111/F9.
3. Load 12000: saturates, and all four slots show font 90.
4. Load 7: only the digit0 slot shows 1110/F8, and the others are 1111/FF. Load 105: 1110/92, 1101/C0, 1011/F9, digit3 blank.
5. Load 42, then load 99 two cycles later: the second load is ignored. Busy falls 14 cycles after the first accept, and the display shows 42 (99, A4).
6. `i_en`=0 mid-scan: outputs go 1111/FF the next cycle, and the index continues. Reset asserted at conversion iteration 7: display is 0 and `o_busy`=0 after release.

Source files
------------

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants, types and helpers for the 4-digit FND scan driver.
//   FND_DIGITS, MAX_VALUE, FONT_BLANK, DIGIT_OFF : display geometry and idle codes
//   FONT_0..FONT_9                                : active-low segment fonts {dp,g,f,e,d,c,b,a}
//   conv_state_t                                  : converter control states
//   bcd_to_font()                                 : BCD nibble to font, blank when out of range
package fnd_pkg;

    localparam int          FND_DIGITS = 4;
    localparam int          BIN_WIDTH  = 14;
    localparam logic [13:0] MAX_VALUE  = 14'd9999;
    localparam logic [3:0]  ITER_LAST  = 4'd13;     // 14 iterations, counted 0..13
    localparam logic [7:0]  FONT_BLANK = 8'hFF;
    localparam logic [3:0]  DIGIT_OFF  = 4'b1111;

    localparam logic [7:0] FONT_0 = 8'hC0;
    localparam logic [7:0] FONT_1 = 8'hF9;
    localparam logic [7:0] FONT_2 = 8'hA4;
    localparam logic [7:0] FONT_3 = 8'hB0;
    localparam logic [7:0] FONT_4 = 8'h99;
    localparam logic [7:0] FONT_5 = 8'h92;
    localparam logic [7:0] FONT_6 = 8'h82;
    localparam logic [7:0] FONT_7 = 8'hF8;
    localparam logic [7:0] FONT_8 = 8'h80;
    localparam logic [7:0] FONT_9 = 8'h90;

    typedef enum logic {
        CONV_IDLE = 1'b0,
        CONV_RUN  = 1'b1
    } conv_state_t;

    function automatic logic [7:0] bcd_to_font(input logic [3:0] d);
        logic [7:0] f;
        case (d)
            4'd0:    f = FONT_0;
            4'd1:    f = FONT_1;
            4'd2:    f = FONT_2;
            4'd3:    f = FONT_3;
            4'd4:    f = FONT_4;
            4'd5:    f = FONT_5;
            4'd6:    f = FONT_6;
            4'd7:    f = FONT_7;
            4'd8:    f = FONT_8;
            4'd9:    f = FONT_9;
            default: f = FONT_BLANK;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_bin2bcd.sv
// bin2bcd_seq: iterative shift-add-3 binary to BCD converter, one bit per clock.
//   clk, reset : clock, synchronous active-high reset (aborts any conversion)
//   start      : capture bin and begin; ignored while busy
//   bin[13:0]  : binary input (caller guarantees <= 9999)
//   busy       : high from the capture edge until the final iteration edge
//   done       : high during the cycle whose edge performs the final iteration
//   bcd[15:0]  : result of the current iteration; valid as the final result when done=1
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    conv_state_t r_state;
    conv_state_t w_state_next;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [15:0] w_adj;
    logic [29:0] w_cat;
    logic [29:0] w_shift;
    logic        w_last;

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    for (genvar gi = 0; gi < FND_DIGITS; gi++) begin : g_adj
        assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                             : r_bcd[gi*4 +: 4];
    end

    assign w_cat   = {w_adj, r_bin};
    assign w_shift = w_cat << 1;
    assign w_last  = (r_state == CONV_RUN) && (r_cnt == ITER_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CONV_IDLE: if (start)  w_state_next = CONV_RUN;
            CONV_RUN:  if (w_last) w_state_next = CONV_IDLE;
            default:               w_state_next = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CONV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == CONV_IDLE) begin
            if (start) begin
                r_bin <= bin;
                r_bcd <= '0;
                r_cnt <= '0;
            end
        end else begin
            r_bcd <= w_shift[29:14];
            r_bin <= w_shift[13:0];
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign busy = (r_state == CONV_RUN);
    assign done = w_last;
    // Exposed combinationally so the caller can commit the result on the same
    // edge that performs the final iteration.
    assign bcd  = w_shift[29:14];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit common-anode FND driver with sequential BCD conversion.
//   SCAN_DIV   : clock cycles each digit is lit (>= 2)
//   i_clk      : system clock
//   i_reset    : synchronous active-high reset
//   i_value    : binary value to display, saturated to 9999 on capture
//   i_load     : capture request, accepted only while o_busy = 0
//   i_en       : display enable, 0 blanks every digit
//   o_busy     : conversion in progress
//   o_digit    : active-low anode enables, bit0 = ones digit
//   o_font     : active-low segments {dp,g,f,e,d,c,b,a}
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [13:0] i_value,
    input  logic        i_load,
    input  logic        i_en,
    output logic        o_busy,
    output logic [3:0]  o_digit,
    output logic [7:0]  o_font
);

    localparam int               PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [13:0]      w_sat;
    logic             w_start;
    logic             w_busy;
    logic             w_done;
    logic [15:0]      w_bcd;
    logic [15:0]      r_disp;
    logic [PRE_W-1:0] r_pre;
    logic [1:0]       r_idx;
    logic [3:0]       w_keep;
    logic [3:0]       w_nib;
    logic             w_show;
    logic [3:0]       r_digit;
    logic [7:0]       r_font;

    assign w_sat   = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;
    assign w_start = i_load && !w_busy;

    bin2bcd_seq u_conv (
        .clk   (i_clk),
        .reset (i_reset),
        .start (w_start),
        .bin   (w_sat),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // The display register only changes when a full conversion completes, so
    // the previous value stays lit throughout a conversion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_disp <= '0;
        end else if (w_done) begin
            r_disp <= w_bcd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // A digit is kept when it or any more significant digit is nonzero;
    // the ones digit is always kept so zero still shows "0".
    assign w_keep[0] = 1'b1;
    for (genvar gi = 1; gi < FND_DIGITS; gi++) begin : g_keep
        assign w_keep[gi] = |r_disp[15:gi*4];
    end

    assign w_nib  = r_disp[{r_idx, 2'b00} +: 4];
    assign w_show = i_en && w_keep[r_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digit <= DIGIT_OFF;
            r_font  <= FONT_BLANK;
        end else if (w_show) begin
            r_digit <= ~(4'b0001 << r_idx);
            r_font  <= bcd_to_font(w_nib);
        end else begin
            r_digit <= DIGIT_OFF;
            r_font  <= FONT_BLANK;
        end
    end

    assign o_busy  = w_busy;
    assign o_digit = r_digit;
    assign o_font  = r_font;

endmodule
